// File: rtl/alu_control.sv
// alu_control: registered ALU operation decoder with one cycle of latency.
// The class code comes from main control (aluop_in). Within a class, funct7
// and funct3 are taken from the instruction. The opcode field never takes part
// in decoding.
// Optional build macro: ALU_CONTROL_MULDIV_EN. When it is defined, R-type
// funct7=0000001 decodes to MUL/DIV. When it is not defined, that funct7 is
// reported as illegal.
module alu_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  input  logic [2:0]  aluop_in,
  output logic [2:0]  aluop,
  output logic        out_valid,
  output logic        illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
`ifdef ALU_CONTROL_MULDIV_EN
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
`endif
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [2:0] CLS_R   = 3'b000;
  localparam logic [2:0] CLS_I   = 3'b001;
  localparam logic [2:0] CLS_MEM = 3'b010;
  localparam logic [2:0] CLS_BR  = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Decode results are packed as {illegal, op}. An illegal combination
  // always drives ADD, so no input value can leave the op undefined.
  localparam logic [3:0] DEC_ILLEGAL = {1'b1, OP_ADD};

  logic [6:0] funct7_p0;
  logic [2:0] funct3_p0;
  logic [2:0] op_p0;
  logic       ill_p0;

  logic [2:0] aluop_p1;
  logic       ill_p1;
  logic       vld_p1;

  // The register-index and opcode fields are intentionally not part of the decode.
  logic       unused_instr_bits;
  assign unused_instr_bits = ^{instruction[24:15], instruction[11:0]};

  function automatic logic [3:0] legal(input logic [2:0] op);
    return {1'b0, op};
  endfunction

  function automatic logic [3:0] decode_r(input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] res;
    res = DEC_ILLEGAL;
    case (f7)
      F7_BASE: begin
        case (f3)
          3'b000:  res = legal(OP_ADD);
          3'b111:  res = legal(OP_AND);
          3'b110:  res = legal(OP_OR);
          3'b100:  res = legal(OP_XOR);
          3'b010:  res = legal(OP_SLT);
          default: res = DEC_ILLEGAL;
        endcase
      end
      F7_ALT: begin
        if (f3 == 3'b000) res = legal(OP_SUB);
      end
      F7_MULDIV: begin
`ifdef ALU_CONTROL_MULDIV_EN
        if (f3 == 3'b000)      res = legal(OP_MUL);
        else if (f3 == 3'b100) res = legal(OP_DIV);
`else
        res = DEC_ILLEGAL;
`endif
      end
      default: res = DEC_ILLEGAL;
    endcase
    return res;
  endfunction

  // I-type arithmetic has no SUB or MUL/DIV, so funct7 is ignored here.
  function automatic logic [3:0] decode_i(input logic [2:0] f3);
    logic [3:0] res;
    case (f3)
      3'b000:  res = legal(OP_ADD);
      3'b111:  res = legal(OP_AND);
      3'b110:  res = legal(OP_OR);
      3'b100:  res = legal(OP_XOR);
      3'b010:  res = legal(OP_SLT);
      default: res = DEC_ILLEGAL;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] decode(input logic [2:0] cls, input logic [6:0] f7,
                                        input logic [2:0] f3);
    logic [3:0] res;
    case (cls)
      CLS_R:   res = decode_r(f7, f3);
      CLS_I:   res = decode_i(f3);
      CLS_MEM: res = legal(OP_ADD);
      CLS_BR:  res = legal(OP_SUB);
      default: res = DEC_ILLEGAL;
    endcase
    return res;
  endfunction

  // Stage p0: combinational field extraction and decode
  always_comb begin
    funct7_p0         = instruction[31:25];
    funct3_p0         = instruction[14:12];
    {ill_p0, op_p0}   = decode(aluop_in, funct7_p0, funct3_p0);
  end

  // Stage p1: register result; hold op/illegal across idle cycles, pulse valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluop_p1 <= OP_ADD;
      ill_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        aluop_p1 <= op_p0;
        ill_p1   <= ill_p0;
      end
    end
  end

  assign aluop     = aluop_p1;
  assign illegal   = ill_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: a vector table, hand-written reset/idle sequences and
// randomized traffic, checked against a rule-list reference model.
module tb_alu_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic [2:0]  aluop_in;
  logic [2:0]  aluop;
  logic        out_valid;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_op;
  logic       exp_ill;
  logic       exp_vld;

`ifdef ALU_CONTROL_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  // Legal R-type combinations as a rule list: funct7, funct3 -> op.
  logic [6:0] r_f7 [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 7'h01};
  logic [2:0] r_f3 [8] = '{3'd0,  3'd0,  3'd7,  3'd6,  3'd4,  3'd2,  3'd0,  3'd4};
  logic [2:0] r_op [8] = '{3'd0,  3'd1,  3'd4,  3'd5,  3'd6,  3'd7,  3'd2,  3'd3};
  // Legal I-type combinations as a rule list: funct3 -> op.
  logic [2:0] i_f3 [5] = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
  logic [2:0] i_op [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

  typedef struct {
    logic [2:0] cls;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [2:0] op;
    logic       ill;
  } vec_t;

  vec_t tbl [17];

  always #5 clk = ~clk;

  alu_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .instruction (instruction),
    .aluop_in    (aluop_in),
    .aluop       (aluop),
    .out_valid   (out_valid),
    .illegal     (illegal)
  );

  function automatic logic [3:0] ref_decode(input logic [2:0] cls, input logic [31:0] ins);
    logic [3:0] res;
    logic [6:0] f7;
    logic [2:0] f3;
    f7  = ins[31:25];
    f3  = ins[14:12];
    res = 4'b1000;
    if (cls == 3'd0) begin
      for (int i = 0; i < 8; i++)
        if (r_f7[i] == f7 && r_f3[i] == f3 && (MULDIV || r_f7[i] != 7'h01))
          res = {1'b0, r_op[i]};
    end else if (cls == 3'd1) begin
      for (int i = 0; i < 5; i++)
        if (i_f3[i] == f3) res = {1'b0, i_op[i]};
    end else if (cls == 3'd2) begin
      res = 4'b0000;
    end else if (cls == 3'd3) begin
      res = 4'b0001;
    end
    return res;
  endfunction

  function automatic logic [31:0] mk_ins(input logic [6:0] f7, input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom();
    r[31:25] = f7;
    r[14:12] = f3;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string name);
    cmp({name, "_aluop"},     32'(aluop),     32'(exp_op));
    cmp({name, "_illegal"},   32'(illegal),   32'(exp_ill));
    cmp({name, "_out_valid"}, 32'(out_valid), 32'(exp_vld));
  endtask

  task automatic drive(input logic v, input logic [2:0] cls, input logic [31:0] ins);
    @(negedge clk);
    in_valid    = v;
    aluop_in    = cls;
    instruction = ins;
  endtask

  task automatic step_check(input string name);
    @(posedge clk);
    #1;
    check_outputs(name);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 7'h00, 3'd0, 3'd0, 1'b0};   // R ADD
    tbl[1]  = '{3'd0, 7'h20, 3'd0, 3'd1, 1'b0};   // R SUB
    tbl[2]  = '{3'd0, 7'h00, 3'd7, 3'd4, 1'b0};   // R AND
    tbl[3]  = '{3'd0, 7'h00, 3'd6, 3'd5, 1'b0};   // R OR
    tbl[4]  = '{3'd0, 7'h00, 3'd4, 3'd6, 1'b0};   // R XOR
    tbl[5]  = '{3'd0, 7'h00, 3'd2, 3'd7, 1'b0};   // R SLT
    tbl[6]  = '{3'd0, 7'h00, 3'd1, 3'd0, 1'b1};   // R unlisted funct3
    tbl[7]  = '{3'd0, 7'h20, 3'd7, 3'd0, 1'b1};   // R alt funct7 with AND funct3
`ifdef ALU_CONTROL_MULDIV_EN
    tbl[8]  = '{3'd0, 7'h01, 3'd0, 3'd2, 1'b0};   // MUL
    tbl[9]  = '{3'd0, 7'h01, 3'd4, 3'd3, 1'b0};   // DIV
`else
    tbl[8]  = '{3'd0, 7'h01, 3'd0, 3'd0, 1'b1};
    tbl[9]  = '{3'd0, 7'h01, 3'd4, 3'd0, 1'b1};
`endif
    tbl[10] = '{3'd1, 7'h20, 3'd0, 3'd0, 1'b0};   // I ADD, funct7 ignored
    tbl[11] = '{3'd1, 7'h00, 3'd7, 3'd4, 1'b0};   // I AND
    tbl[12] = '{3'd1, 7'h7f, 3'd1, 3'd0, 1'b1};   // I unlisted funct3
    tbl[13] = '{3'd2, 7'h7f, 3'd5, 3'd0, 1'b0};   // load/store
    tbl[14] = '{3'd3, 7'h33, 3'd3, 3'd1, 1'b0};   // branch
    tbl[15] = '{3'd7, 7'h00, 3'd0, 3'd0, 1'b1};   // unsupported class
    tbl[16] = '{3'd4, 7'h20, 3'd0, 3'd0, 1'b1};   // unsupported class

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    instruction = 32'h0;
    aluop_in    = 3'd0;
    exp_op      = 3'd0;
    exp_ill     = 1'b0;
    exp_vld     = 1'b0;

    #12;
    check_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Table applied back-to-back, one vector per cycle.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, tbl[i].cls, mk_ins(tbl[i].f7, tbl[i].f3));
      exp_vld = 1'b1;
      exp_op  = tbl[i].op;
      exp_ill = tbl[i].ill;
      step_check($sformatf("vec%0d", i));
    end

    // Idle cycles hold the last result and drop valid.
    drive(1'b1, 3'd0, mk_ins(7'h00, 3'd2));
    exp_vld = 1'b1; exp_op = 3'd7; exp_ill = 1'b0;
    step_check("slt_before_idle");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), $urandom());
      exp_vld = 1'b0;
      step_check($sformatf("idle%0d", i));
    end

    // Asynchronous reset between edges, with an in-flight input discarded.
    drive(1'b1, 3'd0, mk_ins(7'h00, 3'd4));
    exp_vld = 1'b1; exp_op = 3'd6; exp_ill = 1'b0;
    step_check("xor_before_rst");
    drive(1'b1, 3'd3, $urandom());
    #2;
    rst_n = 1'b0;
    #1;
    exp_vld = 1'b0; exp_op = 3'd0; exp_ill = 1'b0;
    check_outputs("async_rst");
    step_check("rst_held_edge");
    drive(1'b0, 3'd3, $urandom());
    rst_n = 1'b1;
    step_check("post_rst_idle");
    drive(1'b1, 3'd1, mk_ins(7'h55, 3'd7));
    exp_vld = 1'b1; exp_op = 3'd4; exp_ill = 1'b0;
    step_check("first_after_rst");

    // Randomized traffic against the rule-list model.
    for (int n = 0; n < 400; n++) begin
      logic       v;
      logic [2:0] cls;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [31:0] ins;
      v   = ($urandom_range(0, 3) != 0);
      cls = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      f3  = 3'($urandom_range(0, 7));
      ins = mk_ins(f7, f3);
      drive(v, cls, ins);
      exp_vld = v;
      if (v) {exp_ill, exp_op} = ref_decode(cls, ins);
      step_check($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; one clock; all state on this clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  instruction and aluop_in are valid this cycle.
REQ-005 instruction  input  32  fields: funct7=[31:25], funct3=[14:12], opcode=[6:0].
REQ-006 aluop_in  input  3  class code from main control.
REQ-007 aluop  output  3  registered ALU operation select.
REQ-008 out_valid  output  1  aluop/illegal valid; 1-cycle pulse per accepted input.
REQ-009 illegal  output  1  registered flag: unsupported class or funct combination.

Function
REQ-010 ALU op codes SHALL be: ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, XOR=110, SLT=111.
REQ-011 aluop_in=000 (R-type) SHALL decode funct7/funct3 as follows:
- 0000000/000 -> ADD
- 0100000/000 -> SUB
- 0000000/111 -> AND
- 0000000/110 -> OR
- 0000000/100 -> XOR
- 0000000/010 -> SLT
- 0000001/000 -> MUL
- 0000001/100 -> DIV
REQ-012 aluop_in=001 (I-type arithmetic) SHALL decode funct3 only, ignoring funct7:
- 000 -> ADD
- 111 -> AND
- 110 -> OR
- 100 -> XOR
- 010 -> SLT
REQ-013 aluop_in=010 (load/store) SHALL produce ADD regardless of instruction.
REQ-014 aluop_in=011 (branch) SHALL produce SUB regardless of instruction.
REQ-015 aluop_in 100..111, and any funct combination not listed for its class, SHALL produce aluop=ADD with illegal=1.
REQ-016 Every listed (legal) combination SHALL produce illegal=0.
REQ-017 Latency SHALL be one cycle: inputs sampled at edge N with in_valid=1 appear on aluop/illegal with out_valid=1 after edge N.
REQ-018 When in_valid=0 at an edge:
- out_valid SHALL go 0;
- aluop and illegal SHALL hold their previous values.
REQ-019 Back-to-back in_valid SHALL produce back-to-back results, one per cycle, with no stall and no backpressure.
REQ-020 opcode bits SHALL NOT affect decoding; the class comes only from aluop_in.
REQ-021 Decoding SHALL contain no X-propagation paths: every aluop_in value maps to a defined output.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force aluop=000, illegal=0, out_valid=0.
REQ-023 On rst_n deassertion, the first in_valid sampled at a following rising edge SHALL be processed normally.
REQ-024 Reset asserted mid-stream SHALL discard any result not yet presented; no stale out_valid after release.

Configuration
REQ-025 Macro ALU_CONTROL_MULDIV_EN SHALL gate MUL/DIV support.
- Defined: funct7=0000001 decodes per REQ-011.
- Undefined: funct7=0000001 in R-type yields aluop=ADD, illegal=1.
- All other behaviour is identical in both builds.

Verification
REQ-026 R-type ADD/SUB: aluop_in=000, funct7=0000000, funct3=000, in_valid=1 -> next cycle aluop=000, illegal=0, out_valid=1; then funct7=0100000 -> aluop=001.
REQ-027 MUL/DIV: aluop_in=000, funct7=0000001, funct3=000 then 100 -> with macro, aluop=010 then 011, illegal=0; without macro, aluop=000, illegal=1.
REQ-028 Load/store and branch: aluop_in=010 with arbitrary instruction -> aluop=000; aluop_in=011 -> aluop=001; illegal=0 for both.
REQ-029 Unsupported class: aluop_in=111, R-type instruction -> aluop=000, illegal=1, out_valid=1.
REQ-030 Reset/idle:
- Assert rst_n=0 asynchronously between edges -> outputs 000/0/0 immediately.
- in_valid=0 for 3 cycles -> out_valid=0 and aluop held.
- Legal I-type input AND (aluop_in=001, funct3=111) -> aluop=100.
